// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its command sequencer:
// widths, select encodings and the sequencer state type.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
    localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
    localparam logic [SEL_W-1:0] OP_AND = 3'b010;
    localparam logic [SEL_W-1:0] OP_OR  = 3'b011;
    localparam logic [SEL_W-1:0] OP_XOR = 3'b100;
    localparam logic [SEL_W-1:0] OP_NOT = 3'b101;
    localparam logic [SEL_W-1:0] OP_SHL = 3'b110;
    localparam logic [SEL_W-1:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // The ALU only produces a meaningful carry for add and subtract.
    function automatic logic op_has_carry(input logic [SEL_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command-side controller for the combinational 4-bit ALU: runs 1..4 passes
// of one operation with the result fed back as operand A, then returns a tagged response.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [1:0]        cmd_cnt,
    input  logic [1:0]        cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic [1:0]        rsp_tag,
    output logic [7:0]        done_cnt
);

    state_t            state_q,    state_d;
    logic [7:0]        done_cnt_q, done_cnt_d;
    logic [SEL_W-1:0]  op_q,       op_d;
    logic [DATA_W-1:0] acc_q,      acc_d;
    logic [DATA_W-1:0] b_q,        b_d;
    logic [1:0]        tag_q,      tag_d;
    logic [1:0]        rem_q,      rem_d;
    logic              carry_q,    carry_d;
    logic              ready_int;

    always_comb begin
        state_d    = state_q;
        done_cnt_d = done_cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        b_d        = b_q;
        tag_d      = tag_q;
        rem_d      = rem_q;
        carry_d    = carry_q;
        ready_int  = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_sel    = '0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        rsp_carry  = 1'b0;
        rsp_zero   = 1'b0;
        rsp_tag    = '0;

        case (state_q)
            IDLE: begin
                ready_int = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    acc_d   = cmd_a;
                    b_d     = cmd_b;
                    tag_d   = cmd_tag;
                    rem_d   = cmd_cnt;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                alu_a   = acc_q;
                alu_b   = b_q;
                alu_sel = op_q;
                acc_d   = alu_out;
                // Carry is stale for logic/shift ops, so only the last arithmetic pass counts.
                carry_d = op_has_carry(op_q) ? alu_carry : 1'b0;
                if (rem_q == 2'd0) begin
                    state_d = RESP;
                end else begin
                    rem_d = rem_q - 2'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = acc_q;
                rsp_carry = carry_q;
                rsp_zero  = (acc_q == '0);
                rsp_tag   = tag_q;
                if (rsp_ready) begin
                    done_cnt_d = done_cnt_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held low while reset is asserted even though the state only clears on the edge.
    assign cmd_ready = ready_int & rst_n;
    assign done_cnt  = done_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Datapath registers need no reset: every output that shows them is gated by state.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        acc_q   <= acc_d;
        b_q     <= b_d;
        tag_q   <= tag_d;
        rem_q   <= rem_d;
        carry_q <= carry_d;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioral ALU that drives a
// deliberately stale carry of 1 for the logic and shift ops.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_a, cmd_b;
    logic [1:0]  cmd_cnt, cmd_tag;
    logic [3:0]  alu_a, alu_b;
    logic [2:0]  alu_sel;
    logic [3:0]  alu_out;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_data;
    logic        rsp_carry, rsp_zero;
    logic [1:0]  rsp_tag;
    logic [7:0]  done_cnt;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cnt(cmd_cnt), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
        .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [4:0] alu_r;
    always_comb begin
        alu_r = 5'd0;
        case (alu_sel)
            OP_ADD: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND: alu_r = {1'b1, alu_a & alu_b};
            OP_OR:  alu_r = {1'b1, alu_a | alu_b};
            OP_XOR: alu_r = {1'b1, alu_a ^ alu_b};
            OP_NOT: alu_r = {1'b1, ~alu_a};
            OP_SHL: alu_r = {1'b1, alu_a[2:0], 1'b0};
            OP_SHR: alu_r = {1'b1, 1'b0, alu_a[3:1]};
            default: alu_r = 5'd0;
        endcase
    end
    assign alu_out   = alu_r[3:0];
    assign alu_carry = alu_r[4];

    typedef struct {
        logic [3:0]  data;
        logic        carry;
        logic [1:0]  tag;
        logic [1:0]  cnt;
        int unsigned acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: latency on each rising rsp_valid, fields on each handshake.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst_n && rsp_valid && !prev_valid) begin
            if (sb.size() == 0) note_fail("unexpected_rsp_valid");
            else check("rsp_latency", cyc - sb[0].acc_cyc, 32'(sb[0].cnt) + 1);
        end
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                note_fail("unexpected_rsp_handshake");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data",  32'(rsp_data),  32'(e.data));
                check("rsp_carry", 32'(rsp_carry), 32'(e.carry));
                check("rsp_zero",  32'(rsp_zero),  32'(e.data == 4'd0));
                check("rsp_tag",   32'(rsp_tag),   32'(e.tag));
            end
        end
        prev_valid = rsp_valid;
    end

    // Call #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] cnt, input logic [1:0] tag,
                         input logic [3:0] ed, input logic ec, input bit push,
                         output int unsigned acc);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_cnt = cnt; cmd_tag = tag;
        cmd_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk); #1;
                acc = cyc;
                if (push) sb.push_back('{data: ed, carry: ec, tag: tag, cnt: cnt, acc_cyc: cyc});
                cmd_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        note_fail("cmd_accept_timeout");
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        if (sb.size() != 0) note_fail("rsp_drain_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc, r;
        bit seen;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cnt = '0; cmd_tag = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_alu_a",     32'(alu_a),     0);
        check("reset_alu_sel",   32'(alu_sel),   0);
        check("reset_done_cnt",  32'(done_cnt),  0);
        rst_n = 1'b1;
        #1;
        check("post_reset_cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk); #1;

        // 1: add with carry out, ALU drive visible during the pass
        issue(OP_ADD, 4'd9, 4'd8, 2'd0, 2'd1, 4'd1, 1'b1, 1'b1, acc);
        check("drive_alu_a",     32'(alu_a),     9);
        check("drive_alu_b",     32'(alu_b),     8);
        check("drive_alu_sel",   32'(alu_sel),   32'(OP_ADD));
        check("drive_cmd_ready", 32'(cmd_ready), 0);
        // 2: sub borrow, then and with masked stale carry
        issue(OP_SUB, 4'd3, 4'd5, 2'd0, 2'd0, 4'hE, 1'b1, 1'b1, acc);
        issue(OP_AND, 4'hF, 4'h0, 2'd0, 2'd2, 4'h0, 1'b0, 1'b1, acc);
        // 3: shift chain 0011 -> 0110 -> 1100 -> 1000
        issue(OP_SHL, 4'b0011, 4'd0, 2'd2, 2'd3, 4'd8, 1'b0, 1'b1, acc);
        // 4: add chain 6, 11, 0 (c=1), 5 (c=0)
        issue(OP_ADD, 4'd1, 4'd5, 2'd3, 2'd1, 4'd5, 1'b0, 1'b1, acc);
        wait_idle();
        check("done_after_5", 32'(done_cnt), 5);

        // 5: back-pressure with a second command waiting
        rsp_ready = 1'b0;
        issue(OP_ADD, 4'd2, 4'd3, 2'd0, 2'd2, 4'd5, 1'b0, 1'b1, acc);
        cmd_op = OP_XOR; cmd_a = 4'hA; cmd_b = 4'h5; cmd_cnt = 2'd0; cmd_tag = 2'd3;
        cmd_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        if (!seen) note_fail("stall_rsp_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 1);
            check("stall_rsp_data",  32'(rsp_data),  5);
            check("stall_rsp_tag",   32'(rsp_tag),   2);
            check("stall_cmd_ready", 32'(cmd_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        r = cyc;
        check("stall_done_cnt",   32'(done_cnt),  6);
        check("stall_cmd_ready1", 32'(cmd_ready), 1);
        issue(OP_XOR, 4'hA, 4'h5, 2'd0, 2'd3, 4'hF, 1'b0, 1'b1, acc);
        check("next_accept_cycle", acc, r + 1);
        wait_idle();
        check("done_after_7", 32'(done_cnt), 7);

        // 6a: reset in the middle of a 4-pass command drops it silently
        issue(OP_ADD, 4'd1, 4'd5, 2'd3, 2'd0, 4'd0, 1'b0, 1'b0, acc);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_cmd_ready", 32'(cmd_ready), 0);
        @(posedge clk); #1;
        check("midreset_rsp_valid", 32'(rsp_valid), 0);
        check("midreset_alu_a",     32'(alu_a),     0);
        check("midreset_alu_b",     32'(alu_b),     0);
        check("midreset_alu_sel",   32'(alu_sel),   0);
        check("midreset_rsp_data",  32'(rsp_data),  0);
        check("midreset_done_cnt",  32'(done_cnt),  0);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midreset_idle_ready", 32'(cmd_ready), 1);

        // 6b: 256 responses wrap done_cnt back to 0
        for (int k = 0; k < 256; k++) begin
            logic [7:0] kv;
            kv = 8'(k);
            issue(OP_OR, kv[3:0], kv[7:4], 2'd0, kv[1:0], kv[3:0] | kv[7:4], 1'b0, 1'b1, acc);
        end
        wait_idle();
        @(posedge clk); #1;
        check("done_cnt_wrap", 32'(done_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-side controller for the 4-bit ALU: accepts operation commands over a valid/ready channel, drives the ALU's operand and select inputs, and captures the combinational result and carry. It can repeat an operation up to 4 passes, feeding the result back as operand A (for shift chains and repeated add/sub). It returns a tagged response over a second valid/ready channel. It sits between the instruction/command source and the existing combinational ALU, which is instantiated beside it at the next level up.

## Interface
Parameters:
- None. Widths are fixed by the ALU: data 4, select 3.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer accepts a command this cycle.
- `cmd_op` in 3: ALU select code. 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not, 110 shl, 111 shr.
- `cmd_a` in 4: initial operand A.
- `cmd_b` in 4: operand B, held for all passes.
- `cmd_cnt` in 2: extra passes; total passes = `cmd_cnt` + 1.
- `cmd_tag` in 2: opaque ID, echoed on the response.
- `alu_a` out 4: to ALU input A.
- `alu_b` out 4: to ALU input B.
- `alu_sel` out 3: to the ALU's select input.
- `alu_out` in 4: ALU result.
- `alu_carry` in 1: ALU carry out.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out 4: final result.
- `rsp_carry` out 1: carry from the final pass (add/sub only).
- `rsp_zero` out 1: high when `rsp_data` == 0.
- `rsp_tag` out 2: echoed `cmd_tag`.
- `done_cnt` out 8: count of completed responses; wraps 255→0.

## Operation
FSM with three states: IDLE, DRIVE, RESP.

- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch op, b, tag and remaining=`cmd_cnt`; load acc=`cmd_a`; go to DRIVE.
- **DRIVE**
  - Drive `alu_a`=acc, `alu_b`=b_reg, `alu_sel`=op.
  - At the clock edge: acc←`alu_out`; carry_reg←`alu_carry` if op is 000/001, else 0.
  - If remaining==0, go to RESP; otherwise remaining−1 and stay in DRIVE.
- **RESP**
  - `rsp_valid`=1. `rsp_data`=acc, `rsp_carry`=carry_reg, `rsp_zero`=(acc==0), `rsp_tag`=tag_reg.
  - On `rsp_ready`: `done_cnt`+1 (mod 256), go to IDLE.

Output and data rules:
- `cmd_ready`=0 in DRIVE and RESP. No command overlap.
- In IDLE and RESP, `alu_a`/`alu_b`/`alu_sel` are driven 0.
- The ALU leaves carry undriven/stale for ops 010–111. The sequencer masks it, so `rsp_carry` is always 0 for those ops.
- Sub: carry is bit 4 of the 5-bit result of A−B (1 when A<B).
- Repeated passes: carry reflects the final pass only, not sticky. All arithmetic is mod 16.
- Response fields are stable while `rsp_valid`=1 and `rsp_ready`=0.
- Reset mid-operation: next edge goes to IDLE. The in-flight command is dropped; no response is issued.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 in the first cycle after reset release. All other outputs are 0; `done_cnt`=0.
- Command accepted at edge T (`cmd_valid`&`cmd_ready`).
  - DRIVE occupies cycles T+1 … T+1+`cmd_cnt`.
  - `rsp_valid` rises at T+2+`cmd_cnt`.
- Response accepted at edge R. `cmd_ready`=1 from R+1, so the throughput ceiling is 1 command per (`cmd_cnt`+3) cycles.
- The ALU path is combinational within one DRIVE cycle. `alu_*` outputs are registered state decodes, not command passthroughs.
- `done_cnt` increments on the same edge as the response handshake.

## Structure
- Shared package `alu_pkg` holds:
  - localparams for the eight op codes (`OP_ADD` … `OP_SHR`);
  - data width 4 and select width 3;
  - the state enum {IDLE, DRIVE, RESP}.
- The existing ALU is reused unchanged, so the existing ALU and this sequencer can share op encodings from the package.
- No sub-module inside the sequencer. The existing ALU is instantiated alongside it in the enclosing top, `alu_subsys`.

## Test plan
1. Add 9+8, cnt 0, tag 1 → `rsp_data`=1, `rsp_carry`=1, `rsp_zero`=0, `rsp_tag`=1; `rsp_valid` at accept+2.
2. Sub 3−5, cnt 0 → `rsp_data`=4'hE, `rsp_carry`=1. Then and 4'hF&4'h0 → `rsp_data`=0, `rsp_zero`=1, `rsp_carry`=0 (mask check).
3. Shl `cmd_a`=4'b0011, cnt 2 → passes 0110, 1100, 1000; `rsp_data`=8, `rsp_carry`=0; `rsp_valid` at accept+4.
4. Add a=1, b=5, cnt 3 → 6, 11, 0 (carry 1), 5; final `rsp_data`=5, `rsp_carry`=0 (final-pass carry, not sticky).
5. Hold `rsp_ready`=0 for 5 cycles with `cmd_valid` high → response fields stable, `cmd_ready`=0. After `rsp_ready`, `done_cnt`+1 and the next command is accepted one cycle later.
6. Assert `rst_n`=0 during DRIVE of a cnt-3 command → next cycle all outputs 0, `done_cnt`=0, no response ever asserted. 256 completed commands → `done_cnt` wraps to 0.
